// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one 32-bit output FIFO write port among N_SRC show-ahead sources.
// Define FIFO_WRITE_ARBITER_TAG_EN to overwrite the top IDW data bits with the source index.
module fifo_write_arbiter #(
  parameter int N_SRC     = 4,
  parameter int MAX_BURST = 16,
  localparam int IDW      = $clog2(N_SRC)
) (
  input  logic                 BUS_CLK,
  input  logic                 RESET_N,
  input  logic                 EN,
  input  logic [N_SRC-1:0]     REQ,
  input  logic [32*N_SRC-1:0]  DATA,
  output logic [N_SRC-1:0]     ACK,
  input  logic                 FIFO_FULL,
  output logic                 FIFO_WRITE,
  output logic [31:0]          FIFO_DATA,
  output logic                 GRANT_VALID,
  output logic [IDW-1:0]       GRANT_ID
);

  localparam int BCW = $clog2(MAX_BURST) + 1;
  localparam logic [IDW-1:0] LAST_RST = IDW'(N_SRC - 1);
  localparam logic [BCW-1:0] CNT_LAST = BCW'(MAX_BURST - 1);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic [IDW-1:0] last_q, last_d;
  logic [BCW-1:0] cnt_q, cnt_d;
  logic [N_SRC-1:0] ack_d;

  logic           pick_valid;
  logic [IDW-1:0] pick_id;
  int             scan_idx;

  logic           grant_req;
  logic           xfer;
  logic           burst_done;
  logic [31:0]    wr_word;

  logic           fifo_write_q;
  logic [31:0]    fifo_data_q;

  // Round-robin search: scan downward so the nearest index after last_q wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    scan_idx   = 0;
    for (int k = N_SRC; k >= 1; k--) begin
      scan_idx = (int'(last_q) + k) % N_SRC;
      if (REQ[scan_idx]) begin
        pick_valid = 1'b1;
        pick_id    = IDW'(scan_idx);
      end
    end
  end

  assign grant_req  = REQ[gid_q];
  assign xfer       = (state_q == S_GRANT) && EN && grant_req && !FIFO_FULL;
  assign burst_done = xfer && (cnt_q == CNT_LAST);

`ifdef FIFO_WRITE_ARBITER_TAG_EN
  assign wr_word = {gid_q, DATA[32*gid_q +: (32 - IDW)]};
`else
  assign wr_word = DATA[32*gid_q +: 32];
`endif

  // NOTE: every signal written here is assigned a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (EN && pick_valid) begin
          state_d = S_GRANT;
          gid_d   = pick_id;
          last_d  = pick_id;
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        ack_d[gid_q] = xfer;
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
        // FIFO_FULL alone only stalls; rotation needs the source or enable to drop, or the burst to run out.
        if (!EN || !grant_req || burst_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge BUS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      gid_q   <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // A word ACKed in the cycle reset arrives is simply lost.
  always_ff @(posedge BUS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fifo_write_q <= 1'b0;
      fifo_data_q  <= '0;
    end else begin
      fifo_write_q <= xfer;
      if (xfer) begin
        fifo_data_q <= wr_word;
      end
    end
  end

  assign ACK         = ack_d;
  assign FIFO_WRITE  = fifo_write_q;
  assign FIFO_DATA   = fifo_data_q;
  assign GRANT_VALID = (state_q == S_GRANT);
  assign GRANT_ID    = gid_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: a directed vector table, hand-written corner
// sequences and randomized traffic, all compared against a transaction-level model each cycle.
module tb_fifo_write_arbiter;

  localparam int N_SRC     = 4;
  localparam int MAX_BURST = 16;
  localparam int IDW       = $clog2(N_SRC);
`ifdef FIFO_WRITE_ARBITER_TAG_EN
  localparam bit TAGGED = 1'b1;
`else
  localparam bit TAGGED = 1'b0;
`endif

  logic                BUS_CLK = 1'b0;
  logic                RESET_N = 1'b0;
  logic                EN = 1'b0;
  logic [N_SRC-1:0]    REQ = '0;
  logic [32*N_SRC-1:0] DATA = '0;
  logic                FIFO_FULL = 1'b0;
  logic [N_SRC-1:0]    ACK;
  logic                FIFO_WRITE;
  logic [31:0]         FIFO_DATA;
  logic                GRANT_VALID;
  logic [IDW-1:0]      GRANT_ID;

  fifo_write_arbiter #(.N_SRC(N_SRC), .MAX_BURST(MAX_BURST)) dut (
    .BUS_CLK    (BUS_CLK),
    .RESET_N    (RESET_N),
    .EN         (EN),
    .REQ        (REQ),
    .DATA       (DATA),
    .ACK        (ACK),
    .FIFO_FULL  (FIFO_FULL),
    .FIFO_WRITE (FIFO_WRITE),
    .FIFO_DATA  (FIFO_DATA),
    .GRANT_VALID(GRANT_VALID),
    .GRANT_ID   (GRANT_ID)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner = granted source or -1 while arbitrating.
  int               m_owner, m_gid, m_last, m_cnt;
  logic             m_wr;
  logic [31:0]      m_data;
  logic [N_SRC-1:0] m_ack;
  logic [31:0]      src_word [N_SRC];

  logic [N_SRC-1:0] o_ack;
  logic             o_valid, o_wr;
  logic [IDW-1:0]   o_gid;
  logic [31:0]      o_data;

  typedef struct {
    logic             en;
    logic [N_SRC-1:0] req;
    logic             full;
    logic [N_SRC-1:0] ack;
    logic             valid;
    logic [IDW-1:0]   gid;
    logic             wr;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] tag_word(input int src, input logic [31:0] d);
    logic [31:0] r;
    r = d;
    r[31 -: IDW] = TAGGED ? IDW'(src) : d[31 -: IDW];
    return r;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_gid   = 0;
    m_last  = N_SRC - 1;
    m_cnt   = 0;
    m_wr    = 1'b0;
    m_data  = '0;
    m_ack   = '0;
  endtask

  // One clock cycle: drive inputs at the falling edge, compare, advance model, wait next falling edge.
  task automatic step(input logic e, input logic [N_SRC-1:0] r, input logic f);
    int found;
    EN        = e;
    REQ       = r;
    FIFO_FULL = f;
    for (int i = 0; i < N_SRC; i++) DATA[32*i +: 32] = src_word[i];
    #1;
    m_ack = '0;
    if (m_owner >= 0 && e && r[m_owner] && !f) m_ack[m_owner] = 1'b1;
    o_ack   = ACK;
    o_valid = GRANT_VALID;
    o_gid   = GRANT_ID;
    o_wr    = FIFO_WRITE;
    o_data  = FIFO_DATA;
    check("model_ack",        32'(o_ack),   32'(m_ack));
    check("model_grant_valid", 32'(o_valid), 32'(m_owner >= 0));
    check("model_grant_id",   32'(o_gid),   32'(m_gid));
    check("model_fifo_write", 32'(o_wr),    32'(m_wr));
    check("model_fifo_data",  o_data,       m_data);
    if (m_owner < 0) begin
      m_wr  = 1'b0;
      found = -1;
      if (e) begin
        for (int k = 1; k <= N_SRC; k++)
          if (found < 0 && r[(m_last + k) % N_SRC]) found = (m_last + k) % N_SRC;
      end
      if (found >= 0) begin
        m_owner = found;
        m_gid   = found;
        m_last  = found;
        m_cnt   = 0;
      end
    end else begin
      if (m_ack != '0) begin
        m_wr   = 1'b1;
        m_data = tag_word(m_owner, src_word[m_owner]);
        m_cnt++;
        src_word[m_owner] = src_word[m_owner] + 32'd1;
      end else begin
        m_wr = 1'b0;
      end
      if (!e || !r[m_owner] || m_cnt == MAX_BURST) m_owner = -1;
    end
    @(negedge BUS_CLK);
  endtask

  task automatic apply_reset(input logic [31:0] base);
    RESET_N   = 1'b0;
    EN        = 1'b0;
    REQ       = '0;
    FIFO_FULL = 1'b0;
    for (int i = 0; i < N_SRC; i++) src_word[i] = base + 32'(i) * 32'h0100_0000;
    model_reset();
    #1;
    check("reset_ack",         32'(ACK),         32'd0);
    check("reset_fifo_write",  32'(FIFO_WRITE),  32'd0);
    check("reset_fifo_data",   FIFO_DATA,        32'd0);
    check("reset_grant_valid", 32'(GRANT_VALID), 32'd0);
    check("reset_grant_id",    32'(GRANT_ID),    32'd0);
    repeat (2) @(negedge BUS_CLK);
    RESET_N = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    // en, req, full | ack, valid, gid, write
    tbl[0]  = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'b1001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 4'b1001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1};
    tbl[3]  = '{1'b1, 4'b1001, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1};
    tbl[4]  = '{1'b1, 4'b1001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[5]  = '{1'b1, 4'b1000, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1};
    tbl[6]  = '{1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[7]  = '{1'b1, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0};
    tbl[8]  = '{1'b0, 4'b1000, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1};
    tbl[9]  = '{1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0};
    tbl[10] = '{1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0};
    tbl[11] = '{1'b1, 4'b1010, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0};
    tbl[12] = '{1'b1, 4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0};
    tbl[13] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1};
    tbl[14] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0};

    @(negedge BUS_CLK);

    // Sole requester 2: one idle cycle, 16 words, one idle cycle, re-grant.
    apply_reset(32'h1000_0000);
    src_word[2] = 32'hA000_0000;
    for (int c = 0; c <= 18; c++) begin
      step(1'b1, 4'b0100, 1'b0);
      check("solo_ack", 32'(o_ack), ((c >= 1 && c <= 16) || c == 18) ? 32'h4 : 32'h0);
      check("solo_valid", 32'(o_valid), 32'((c >= 1 && c <= 16) || c == 18));
      check("solo_write", 32'(o_wr), 32'(c >= 2 && c <= 17));
      if (c >= 2 && c <= 17) check("solo_data", o_data, tag_word(2, 32'hA000_0000 + 32'(c - 2)));
      if (c == 18) check("solo_regrant_id", 32'(o_gid), 32'd2);
    end

    // All four requesting: grants 0,1,2,3,0 with 16 words each and one idle cycle between.
    apply_reset(32'h2000_0000);
    for (int c = 0; c < 5 * 17; c++) begin
      step(1'b1, 4'b1111, 1'b0);
      check("rr_ack", 32'(o_ack), (c % 17 == 0) ? 32'h0 : (32'h1 << ((c / 17) % 4)));
      check("rr_valid", 32'(o_valid), 32'(c % 17 != 0));
      if (c % 17 != 0) check("rr_grant_id", 32'(o_gid), 32'((c / 17) % 4));
    end

    // Source 1 stalled by FIFO_FULL after 5 words for 10 cycles, then 11 more words.
    apply_reset(32'h3000_0000);
    for (int c = 0; c <= 27; c++) begin
      step(1'b1, 4'b0010, (c >= 6 && c <= 15));
      check("stall_ack", 32'(o_ack), ((c >= 1 && c <= 5) || (c >= 16 && c <= 26)) ? 32'h2 : 32'h0);
      check("stall_write", 32'(o_wr), 32'((c >= 2 && c <= 6) || (c >= 17 && c <= 27)));
      check("stall_valid", 32'(o_valid), 32'(c >= 1 && c <= 26));
      if (c >= 1 && c <= 26) check("stall_grant_id", 32'(o_gid), 32'd1);
    end

    // Vector table: early REQ drop, FIFO_FULL stall, EN deassert, rotation order.
    apply_reset(32'h4000_0000);
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].en, tbl[i].req, tbl[i].full);
      check($sformatf("tbl%0d_ack", i),   32'(o_ack),   32'(tbl[i].ack));
      check($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_gid", i),   32'(o_gid),   32'(tbl[i].gid));
      check($sformatf("tbl%0d_write", i), 32'(o_wr),    32'(tbl[i].wr));
    end

    // Asynchronous reset in the middle of source 1's burst.
    apply_reset(32'h5000_0000);
    for (int c = 0; c <= 20; c++) step(1'b1, 4'b1111, 1'b0);
    #1;
    check("midrst_pre_ack", 32'(ACK), 32'h2);
    #1;
    RESET_N = 1'b0;
    #1;
    check("midrst_ack",         32'(ACK),         32'd0);
    check("midrst_fifo_write",  32'(FIFO_WRITE),  32'd0);
    check("midrst_fifo_data",   FIFO_DATA,        32'd0);
    check("midrst_grant_valid", 32'(GRANT_VALID), 32'd0);
    check("midrst_grant_id",    32'(GRANT_ID),    32'd0);
    @(negedge BUS_CLK);
    RESET_N = 1'b1;
    model_reset();
    step(1'b1, 4'b1111, 1'b0);
    check("postrst_idle", 32'(o_valid), 32'd0);
    step(1'b1, 4'b1111, 1'b0);
    check("postrst_grant_id", 32'(o_gid), 32'd0);
    check("postrst_ack",      32'(o_ack), 32'h1);

    // All-ones words from sources 1 and 3 (tag replaces the top IDW bits).
    apply_reset(32'h6000_0000);
    src_word[1] = 32'hFFFF_FFFF;
    src_word[3] = 32'hFFFF_FFFF;
    step(1'b1, 4'b1010, 1'b0);
    step(1'b1, 4'b1010, 1'b0);
    step(1'b1, 4'b1000, 1'b0);
    check("tag_src1_data", o_data, TAGGED ? 32'h7FFF_FFFF : 32'hFFFF_FFFF);
    step(1'b1, 4'b1000, 1'b0);
    step(1'b1, 4'b1000, 1'b0);
    check("tag_src3_grant", 32'(o_gid), 32'd3);
    step(1'b1, 4'b0000, 1'b0);
    check("tag_src3_data", o_data, 32'hFFFF_FFFF);

    // Randomized traffic against the model.
    apply_reset(32'h7000_0000);
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 15) != 0), N_SRC'($urandom), ($urandom_range(0, 5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the single 32-bit output FIFO write port (FIFO_WRITE/FIFO_DATA, flow-controlled by FIFO_FULL) among N_SRC data sources.
- Each source exposes a show-ahead read interface (REQ = not-empty, DATA valid while REQ high, ACK = read strobe).
- The arbiter grants one source at a time for bursts of up to MAX_BURST words, then rotates to the next source.
- Sits between per-channel readout FIFOs and the Ethernet/USB output FIFO; globally gated by EN from a gpio register bit.

Parameters:
- N_SRC, 4, number of requesters, 2..16; IDW = clog2(N_SRC) is derived internally.
- MAX_BURST, 16, maximum consecutive words per grant, 1..256.

Ports:
- BUS_CLK  input  1  single clock; everything is sequential on its rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- EN  input  1  global enable; low blocks new grants and transfers.
- REQ  input  N_SRC  per-source data available.
- DATA  input  32*N_SRC  per-source word; source i on bits [32*i+31:32*i].
- ACK  output  N_SRC  per-source read strobe, one cycle per word taken; combinational from state and inputs.
- FIFO_FULL  input  1  output FIFO almost-full; must assert with at least 1 word of margin.
- FIFO_WRITE  output  1  registered write strobe to the output FIFO.
- FIFO_DATA  output  32  registered write data.
- GRANT_VALID  output  1  high while in GRANT state.
- GRANT_ID  output  IDW  index of the granted source.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - state=IDLE; ACK=0; FIFO_WRITE=0; FIFO_DATA=0; GRANT_VALID=0; GRANT_ID=0.
  - last-granted pointer = N_SRC-1, so source 0 has first priority; burst_cnt=0.
- Reset asserted mid-burst: outputs clear immediately. Any word already ACKed but not yet written is dropped.
- IDLE state:
  - If EN=1 and any REQ bit is set: pick the first set REQ bit searching from last+1 upward with wrap-around. Register GRANT_ID to that index, set last to it, burst_cnt=0, go to GRANT.
  - Otherwise stay in IDLE.
  - Arbitration costs exactly 1 idle cycle; ACK=0 in IDLE.
- GRANT state (g = GRANT_ID):
  - Transfer condition: xfer = EN & REQ[g] & !FIFO_FULL.
  - ACK[g] = xfer, combinational, same cycle. All other ACK bits are 0.
  - On xfer: the next edge registers FIFO_DATA=DATA[g] and FIFO_WRITE=1, so latency is 1 cycle from ACK to the write. burst_cnt increments.
  - When xfer=0, FIFO_WRITE=0 next cycle and FIFO_DATA holds its previous value.
- Leaving GRANT (return to IDLE; GRANT_VALID drops on the next edge):
  - REQ[g]=0, which ends the burst early.
  - EN=0.
  - xfer with burst_cnt==MAX_BURST-1, i.e. the burst is exhausted.
- FIFO_FULL during GRANT: stall with no ACK and no write. Grant and burst_cnt are held; transfers resume when FIFO_FULL clears. FIFO_FULL does not cause rotation.
- Fairness:
  - After a burst ends for any reason, the next search starts at g+1.
  - A sole requester is re-granted after 1 IDLE cycle, giving a maximum throughput of MAX_BURST words per MAX_BURST+1 cycles.
- Simultaneous events: if REQ[g] falls in the same cycle the burst limit would be hit, there is no xfer; go to IDLE. In every case, a word is counted only when ACK is asserted.
- burst_cnt width is clog2(MAX_BURST)+1 and it never wraps; it resets to 0 on every grant.

Optional Feature:
- Macro: FIFO_WRITE_ARBITER_TAG_EN.
- Defined: FIFO_DATA[31:32-IDW] = registered GRANT_ID of the transferring source; FIFO_DATA[31-IDW:0] = DATA[g][31-IDW:0]. This lets the host demultiplex channels.
- Undefined: FIFO_DATA = DATA[g] unmodified (pure pass-through). Ports and timing are identical in both builds.

Test Plan:
- Reset, EN=1, only REQ[2]=1 with DATA=0xA0000000+k:
  - 1 IDLE cycle first, then ACK[2] pulses on 16 consecutive cycles.
  - FIFO_WRITE follows 1 cycle later with data k=0..15.
  - Then 1 IDLE cycle, then re-grant to source 2.
- REQ=4'b1111 continuously, MAX_BURST=16: GRANT_ID sequence 0,1,2,3,0. Each burst is exactly 16 writes, separated by 1 idle cycle.
- Source 1 granted; FIFO_FULL raised after 5 words for 10 cycles:
  - No ACK or FIFO_WRITE during the stall; GRANT_ID stays 1.
  - 11 further words follow once FIFO_FULL clears.
- Source 0 REQ drops after 3 words while REQ[3]=1: burst ends after 3 writes; next grant is 3.
- EN deasserted mid-burst: ACK=0 the same cycle; FIFO_WRITE=0 one cycle later; IDLE with no new grant until EN=1.
- RESET_N pulsed low asynchronously mid-burst:
  - All outputs are 0 immediately.
  - After release the first grant goes to source 0 when REQ=4'b1111.
- With TAG_EN defined, N_SRC=4, source 3 sending 0xFFFFFFFF: FIFO_DATA=0xFFFFFFFF with top 2 bits = 2'b11. Source 1 sending 0xFFFFFFFF gives 0x7FFFFFFF.
